// File: rtl/arb_req_fifo_if.sv
// Handshake bundle for arb_req_fifo: upstream write ports, arbiter request/grant loop and the
// registered output stage. The design uses the slave view; the environment uses the master view.
interface arb_req_fifo_if #(
    parameter int DW = 8
);
    logic [2:0]      in_vld;
    logic [2:0]      in_rdy;
    logic [3*DW-1:0] in_data;
    logic [2:0]      req_vld;
    logic [2:0]      grant;
    logic            arb_en;
    logic            out_vld;
    logic            out_rdy;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            err;

    modport master (
        output in_vld, in_data, grant, out_rdy,
        input  in_rdy, req_vld, arb_en, out_vld, out_data, out_src, err
    );

    modport slave (
        input  in_vld, in_data, grant, out_rdy,
        output in_rdy, req_vld, arb_en, out_vld, out_data, out_src, err
    );
endinterface

// File: rtl/arb_req_fifo.sv
// Three per-channel request FIFOs feeding a round-robin arbiter, with a registered output stage.
// Optional grant checking (sticky err, pop suppressed on multi-hot grant) under ARB_REQ_FIFO_CHK_EN.
module arb_req_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         srst,
    arb_req_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [3][DEPTH];
    logic [AW-1:0] wr_ptr [3];
    logic [AW-1:0] rd_ptr [3];
    logic [AW:0]   count [3];

    logic [2:0]    full;
    logic [2:0]    empty;
    logic [2:0]    push;
    logic [2:0]    pop;
    logic          out_free;
    logic [1:0]    pop_idx;
    logic [DW-1:0] head;

    logic          out_vld_q;
    logic [DW-1:0] out_data_q;
    logic [1:0]    out_src_q;

    // Flags come only from registered counts so req_vld never loops back through the arbiter.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < 3; i++) begin
            full[i]  = (count[i] == FULL_CNT);
            empty[i] = (count[i] == '0);
        end
    end

    assign bus.in_rdy  = ~full;
    assign bus.req_vld = ~empty;
    assign push        = bus.in_vld & ~full;
    assign out_free    = ~out_vld_q | bus.out_rdy;

`ifdef ARB_REQ_FIFO_CHK_EN
    logic one_hot0;
    logic bad_grant;
    logic err_q;

    assign one_hot0  = ((bus.grant & (bus.grant - 3'd1)) == 3'b000);
    assign pop       = (one_hot0 && out_free) ? (bus.grant & ~empty) : 3'b000;
    assign bad_grant = ~one_hot0 | (|(bus.grant & empty));

    always_ff @(posedge clk) begin
        if (srst) begin
            err_q <= 1'b0;
        end else if (bad_grant) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic [2:0] cand;

    // A multi-hot grant resolves to the lowest granted non-empty channel.
    always_comb begin
        cand = bus.grant & ~empty;
        pop  = 3'b000;
        if (out_free) begin
            if (cand[0]) begin
                pop = 3'b001;
            end else if (cand[1]) begin
                pop = 3'b010;
            end else if (cand[2]) begin
                pop = 3'b100;
            end
        end
    end

    assign bus.err = 1'b0;
`endif

    always_comb begin
        pop_idx = 2'd0;
        if (pop[1]) begin
            pop_idx = 2'd1;
        end
        if (pop[2]) begin
            pop_idx = 2'd2;
        end
    end

    assign head       = mem[pop_idx][rd_ptr[pop_idx]];
    assign bus.arb_en = |pop;

    // Storage needs no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= bus.in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Data and source hold after the consumer takes the word; only the valid drops.
    always_ff @(posedge clk) begin
        if (srst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= 2'd0;
        end else if (|pop) begin
            out_vld_q  <= 1'b1;
            out_data_q <= head;
            out_src_q  <= pop_idx;
        end else if (bus.out_rdy) begin
            out_vld_q  <= 1'b0;
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign bus.out_src  = out_src_q;
endmodule
